mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter n, default 16, meaning the data and address width in bits.
REQ-002 The block SHALL have parameter AW, default 8, meaning the index width; the array holds 2**AW words of n bits.
REQ-003 The block SHALL have parameter LAT, default 2, range 1..15, meaning the number of wait cycles between request acceptance and response.
REQ-004 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  SHALL be the reset: one clock; reset is asynchronous and active-high.
REQ-006 Port req  input  1  SHALL indicate that the requester presents a valid access.
REQ-007 Port we  input  1  SHALL select a write when 1 and a read when 0; sampled with req.
REQ-008 Port addr  input  n  SHALL be the word address; sampled with req.
REQ-009 Port wdata  input  n  SHALL be the write data; sampled with req.
REQ-010 Port busy  output  1  SHALL be high while an access is in flight; while high, req is ignored.
REQ-011 Port ready  output  1  SHALL pulse high for exactly one cycle when the access completes.
REQ-012 Port rdata  output  n  SHALL carry the read word, valid when ready is high after a read.
REQ-013 Port err  output  1  SHALL be high with ready when the accepted address had any nonzero bit above AW-1.

Function
REQ-014 The control path SHALL use a three-state FSM: IDLE, WAIT, RESP.
REQ-015 IDLE: if req=1 the block SHALL latch we, addr and wdata, load the wait counter with LAT-1, and go to WAIT; otherwise it SHALL stay in IDLE.
REQ-016 WAIT: the counter SHALL decrement each cycle; when the counter is 0, the block SHALL perform the access and go to RESP.
REQ-017 RESP: ready SHALL be 1 for one cycle, then the FSM SHALL return to IDLE; req in RESP SHALL be ignored.
REQ-018 Latency from req sampled in IDLE to ready high SHALL be LAT+1 cycles, with at least one idle cycle between consecutive accesses.
REQ-019 busy SHALL be 1 in WAIT and RESP, and 0 in IDLE.
REQ-020 Writes SHALL update the array at index addr[AW-1:0] on the cycle leaving WAIT; rdata after a write SHALL hold its previous value.
REQ-021 Reads SHALL capture array[addr[AW-1:0]] into a registered rdata on the cycle leaving WAIT; rdata SHALL hold until the next read completes.
REQ-022 Out-of-range addresses SHALL alias (upper bits dropped): the access still completes and err=1 alongside ready.
REQ-023 Changes on req, we, addr or wdata while busy=1 SHALL NOT affect the in-flight access.

Reset
REQ-024 Asserting reset SHALL force state=IDLE, counter=0, busy=0, ready=0, err=0 and rdata=0 asynchronously.
REQ-025 Reset mid-access SHALL abort the access; a write aborted before leaving WAIT SHALL NOT modify the array.
REQ-026 Array contents SHALL NOT be cleared by reset; the bench SHALL initialise them by writes.
REQ-027 A req present on the first edge after reset deasserts SHALL be accepted.

Structure
REQ-028 The state enum (IDLE, WAIT, RESP) and the default widths SHALL live in shared package mem_pkg.
REQ-029 The storage array SHALL be a sub-module mem_array (synchronous write port, combinational read), instantiated once; the FSM and counter SHALL stay in mem_responder.
REQ-030 With default parameters, the port widths SHALL match the 16-bit datapath's addr/writedata/readdata buses.

Verification
REQ-031 Write then read: write addr=0x0005, wdata=0xBEEF, then read 0x0005 -> ready 3 cycles after each req; rdata=0xBEEF, err=0.
REQ-032 Aliasing: write 0x0103 with 0x1234, then read 0x0003 -> rdata=0x1234; err=1 on the write, err=0 on the read.
REQ-033 Busy ignore: req a read of 0x0005, then toggle req, we=1, addr=0x0005, wdata=0x0000 during WAIT -> exactly one ready pulse; rdata=0xBEEF; array unchanged.
REQ-034 Reset mid-write: req a write of 0x0007 with 0xAAAA, assert reset in WAIT -> busy=0, ready=0 immediately; a later read of 0x0007 returns the prior value.
REQ-035 Back-to-back: hold req=1 across four reads of 0x00..0x03 -> one ready per access, ready spaced LAT+2 cycles apart.
REQ-036 Parameter sweep: repeat REQ-031 with LAT=1 and LAT=15 -> ready latency 2 and 16 cycles respectively.

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared state encoding and default widths for mem_responder
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int IDX_W_DEF  = 8;
    localparam int LAT_DEF    = 2;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================================
// mem_array : 2**AW x DW storage, synchronous write, combinational read
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_array #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : fixed-latency single-port memory responder (IDLE/WAIT/RESP)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_responder
    import mem_pkg::*;
#(
    parameter int n   = DATA_W_DEF,
    parameter int AW  = IDX_W_DEF,
    parameter int LAT = LAT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         we,
    input  logic [n-1:0] addr,
    input  logic [n-1:0] wdata,
    output logic         busy,
    output logic         ready,
    output logic [n-1:0] rdata,
    output logic         err
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [n-1:0]       r_addr;
    logic [n-1:0]       r_wdata;
    logic               r_busy;
    logic               r_ready;
    logic               r_err;
    logic [n-1:0]       r_rdata;

    logic               w_access;
    logic               w_mem_we;
    logic               w_oob;
    logic [n-1:0]       w_mem_rdata;

    // The access fires on the edge that leaves WAIT; gating on state means an
    // asynchronous reset in WAIT suppresses the write before that edge.
    assign w_access = (r_state == WAIT) && (r_cnt == '0);
    assign w_mem_we = w_access && r_we;

    generate
        if (n > AW) begin : g_oob
            assign w_oob = |r_addr[n-1:AW];
        end else begin : g_no_oob
            assign w_oob = 1'b0;
        end
    endgenerate

    mem_array #(
        .DW (n),
        .AW (AW)
    ) u_mem_array (
        .i_clk   (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_addr[AW-1:0]),
        .i_wdata (r_wdata),
        .i_raddr (r_addr[AW-1:0]),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_we    <= we;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_cnt   <= CNT_W'(LAT - 1);
                        r_busy  <= 1'b1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        if (!r_we) begin
                            r_rdata <= w_mem_rdata;
                        end
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    // Registered pulse lands in the following IDLE cycle,
                    // which also enforces one idle cycle between accesses.
                    r_ready <= 1'b1;
                    r_err   <= w_oob;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign ready = r_ready;
    assign err   = r_err;
    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// tb_mem_responder : directed self-checking bench for mem_responder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;

    logic        busy,  ready,  err;
    logic [15:0] rdata;
    logic        busy1, ready1, err1;
    logic [15:0] rdata1;
    logic        busy15, ready15, err15;
    logic [15:0] rdata15;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_responder #(.n(16), .AW(8), .LAT(2)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .ready(ready), .rdata(rdata), .err(err)
    );

    mem_responder #(.n(16), .AW(8), .LAT(1)) u_dut_lat1 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy1), .ready(ready1), .rdata(rdata1), .err(err1)
    );

    mem_responder #(.n(16), .AW(8), .LAT(15)) u_dut_lat15 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy15), .ready(ready15), .rdata(rdata15), .err(err15)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entered #1 after a rising edge; returns #1 after the edge that raised ready.
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          output int lat);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 0;
        while (!ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic sweep(input logic w, input logic [15:0] a, input logic [15:0] d,
                         output int l2, output int l1, output int l15);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        l2 = -1; l1 = -1; l15 = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (ready   && l2  < 0) l2  = c;
            if (ready1  && l1  < 0) l1  = c;
            if (ready15 && l15 < 0) l15 = c;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, l1, l15, cnt, pulses;
        logic [15:0] exp_b2b [4];

        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  busy,  0);
        check("rst_ready", ready, 0);
        check("rst_err",   err,   0);
        check("rst_rdata", rdata, 0);

        // Release reset and present req in the same step: first edge accepts it.
        reset = 1'b0;
        access(1'b1, 16'h0005, 16'hBEEF, lat);
        check("wr5_lat", lat, 3);
        check("wr5_err", err, 0);
        check("wr5_rdata_held", rdata, 0);
        @(posedge clk); #1;
        check("wr5_ready_one_cycle", ready, 0);
        check("wr5_busy_idle", busy, 0);
        access(1'b0, 16'h0005, 16'h0000, lat);
        check("rd5_lat", lat, 3);
        check("rd5_rdata", rdata, 16'hBEEF);
        check("rd5_err", err, 0);

        access(1'b1, 16'h0103, 16'h1234, lat);
        check("alias_wr_lat", lat, 3);
        check("alias_wr_err", err, 1);
        access(1'b0, 16'h0003, 16'h0000, lat);
        check("alias_rd_rdata", rdata, 16'h1234);
        check("alias_rd_err", err, 0);

        // Busy ignore: disturb inputs while in flight, drop req as ready appears.
        req = 1'b1; we = 1'b0; addr = 16'h0005; wdata = 16'h5555;
        @(posedge clk); #1;
        we = 1'b1; wdata = 16'h0000;
        check("bsy_busy", busy, 1);
        pulses = 0;
        cnt = 0;
        while (!ready && cnt < 40) begin
            @(posedge clk); #1;
            req = ~req;
            cnt++;
        end
        req = 1'b0;
        if (ready) pulses++;
        check("bsy_rdata", rdata, 16'hBEEF);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        check("bsy_pulses", pulses, 1);
        access(1'b0, 16'h0005, 16'h0000, lat);
        check("bsy_array_kept", rdata, 16'hBEEF);

        // Reset mid-write.
        access(1'b1, 16'h0007, 16'h1111, lat);
        check("rmw_pre_lat", lat, 3);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 16'h0007; wdata = 16'hAAAA;
        @(posedge clk); #1;
        req = 1'b0;
        check("rmw_busy_wait", busy, 1);
        reset = 1'b1;
        #1;
        check("rmw_busy_rst",  busy,  0);
        check("rmw_ready_rst", ready, 0);
        check("rmw_rdata_rst", rdata, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        access(1'b0, 16'h0007, 16'h0000, lat);
        check("rmw_rd_lat", lat, 3);
        check("rmw_rd_rdata", rdata, 16'h1111);

        // Back-to-back reads with req held high.
        exp_b2b[0] = 16'h00A0; exp_b2b[1] = 16'h00A1;
        exp_b2b[2] = 16'h00A2; exp_b2b[3] = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            access(1'b1, 16'(i), exp_b2b[i], lat);
        end
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            do begin
                @(posedge clk); #1;
                cnt++;
            end while (!ready && cnt < 40);
            check($sformatf("b2b_spacing_%0d", k), cnt, 4);
            check($sformatf("b2b_rdata_%0d", k), rdata, exp_b2b[k]);
            addr = 16'(k + 1);
            if (k == 3) req = 1'b0;
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        check("b2b_no_extra", pulses, 0);

        // Latency sweep across LAT=2, 1, 15.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sweep(1'b1, 16'h0005, 16'hBEEF, lat, l1, l15);
        check("sw_wr_lat2",  lat, 3);
        check("sw_wr_lat1",  l1,  2);
        check("sw_wr_lat15", l15, 16);
        sweep(1'b0, 16'h0005, 16'h0000, lat, l1, l15);
        check("sw_rd_lat2",  lat, 3);
        check("sw_rd_lat1",  l1,  2);
        check("sw_rd_lat15", l15, 16);
        check("sw_rd_rdata1",  rdata1,  16'hBEEF);
        check("sw_rd_rdata15", rdata15, 16'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
